// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue side of the ALU. Decodes MIPS opcode/funct into the
// 3-bit ALU control, holds the ALU operands/control stable for a per-op settle
// window, then registers the ALU result as a valid/ready response.
// Ports:
//   i_clk, i_rst_n (async active-low)
//   request : i_req_valid, o_req_ready, i_req_opcode[5:0], i_req_funct[5:0],
//             i_req_data_a[31:0], i_req_data_b[31:0]
//   ALU     : o_alu_inp_a[31:0], o_alu_inp_b[31:0], o_alu_ctrl[2:0], i_alu_result[31:0]
//   response: o_rsp_valid, i_rsp_ready, o_rsp_result[31:0], o_rsp_zero,
//             o_rsp_illegal, o_rsp_div_zero
//   ALU_SEQ_PERF_EN defined: o_perf_ops[31:0] (response handshakes),
//             o_perf_busy[31:0] (cycles spent in EXEC)
module alu_op_sequencer #(
  parameter int SIMPLE_LAT = 1,
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_req_opcode,
  input  logic [5:0]  i_req_funct,
  input  logic [31:0] i_req_data_a,
  input  logic [31:0] i_req_data_b,
  output logic [31:0] o_alu_inp_a,
  output logic [31:0] o_alu_inp_b,
  output logic [2:0]  o_alu_ctrl,
  input  logic [31:0] i_alu_result,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_zero,
  output logic        o_rsp_illegal,
  output logic        o_rsp_div_zero
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] o_perf_ops,
  output logic [31:0] o_perf_busy
`endif
);
  localparam int MAX_LAT = (SIMPLE_LAT > MULT_LAT) ?
                           ((SIMPLE_LAT > DIV_LAT) ? SIMPLE_LAT : DIV_LAT) :
                           ((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT);
  localparam int CW = $clog2(MAX_LAT) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_inp_a, r_inp_b, r_result;
  logic [2:0]    r_ctrl;
  logic          r_illegal, r_div_zero, r_zero;
  logic [2:0]    w_ctrl;
  logic [CW-1:0] w_lat;
  logic          w_accept, w_handshake;
  // 3'b111 is never produced by a legal op, so it doubles as the illegal marker
  always_comb begin
    w_ctrl = 3'b111;
    if (i_req_opcode == 6'h00)
      case (i_req_funct)
        6'h20, 6'h21: w_ctrl = 3'b000;
        6'h22, 6'h23: w_ctrl = 3'b001;
        6'h18:        w_ctrl = 3'b010;
        6'h1A:        w_ctrl = 3'b011;
        6'h24:        w_ctrl = 3'b100;
        6'h25:        w_ctrl = 3'b101;
        6'h26:        w_ctrl = 3'b110;
        default:      w_ctrl = 3'b111;
      endcase
    else
      case (i_req_opcode)
        6'h08, 6'h09, 6'h23, 6'h2B: w_ctrl = 3'b000;
        6'h04, 6'h05:               w_ctrl = 3'b001;
        6'h0C:                      w_ctrl = 3'b100;
        6'h0D:                      w_ctrl = 3'b101;
        6'h0E:                      w_ctrl = 3'b110;
        default:                    w_ctrl = 3'b111;
      endcase
  end
  // counter is loaded with LAT-1 so the capture edge lands exactly LAT edges after accept
  assign w_lat = (w_ctrl == 3'b010) ? CW'(MULT_LAT - 1) :
                 (w_ctrl == 3'b011) ? CW'(DIV_LAT - 1) : CW'(SIMPLE_LAT - 1);
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_handshake = o_rsp_valid & i_rsp_ready;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_inp_a    <= '0;
      r_inp_b    <= '0;
      r_ctrl     <= 3'b111;
      r_illegal  <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_inp_a    <= i_req_data_a;
      r_inp_b    <= i_req_data_b;
      r_ctrl     <= w_ctrl;
      r_illegal  <= (w_ctrl == 3'b111);
      r_div_zero <= (w_ctrl == 3'b011) && (i_req_data_b == '0);
      r_cnt      <= w_lat;
      r_state    <= S_EXEC;
    end else if (r_state == S_EXEC) begin
      if (r_cnt == '0) begin
        r_result <= r_div_zero ? 32'hFFFF_FFFF : i_alu_result;
        r_zero   <= !r_div_zero && (i_alu_result == '0);
        r_state  <= S_RESP;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (w_handshake) begin
      r_state <= S_IDLE;
    end
  end
  assign o_alu_inp_a    = r_inp_a;
  assign o_alu_inp_b    = r_inp_b;
  assign o_alu_ctrl     = r_ctrl;
  assign o_rsp_result   = r_result;
  assign o_rsp_zero     = r_zero;
  assign o_rsp_illegal  = r_illegal;
  assign o_rsp_div_zero = r_div_zero;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] r_perf_ops, r_perf_busy;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_ops  <= '0;
      r_perf_busy <= '0;
    end else begin
      r_perf_ops  <= r_perf_ops + {31'd0, w_handshake};
      r_perf_busy <= r_perf_busy + {31'd0, (r_state == S_EXEC)};
    end
  end
  assign o_perf_ops  = r_perf_ops;
  assign o_perf_busy = r_perf_busy;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vector table plus hand-written backpressure and
// mid-operation reset sequences for alu_op_sequencer; a small ALU model answers
// the DUT's operand/control outputs.
module tb_alu_op_sequencer;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, rsp_ready = 1;
  logic [5:0]  req_opcode = 0, req_funct = 0;
  logic [31:0] req_a = 0, req_b = 0, alu_res;
  logic        req_ready, rsp_valid, rsp_zero, rsp_illegal, rsp_div_zero;
  logic [31:0] alu_a, alu_b, rsp_result;
  logic [2:0]  alu_ctrl;
  int checks = 0, fails = 0;

  alu_op_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_opcode(req_opcode), .i_req_funct(req_funct),
    .i_req_data_a(req_a), .i_req_data_b(req_b),
    .o_alu_inp_a(alu_a), .o_alu_inp_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_result(alu_res),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero),
    .o_rsp_illegal(rsp_illegal), .o_rsp_div_zero(rsp_div_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = alu_a;
    case (alu_ctrl)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_a - alu_b;
      3'b010: alu_res = alu_a * alu_b;
      3'b011: alu_res = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
      3'b100: alu_res = alu_a & alu_b;
      3'b101: alu_res = alu_a | alu_b;
      3'b110: alu_res = alu_a ^ alu_b;
      default: alu_res = alu_a;
    endcase
  end

  typedef struct {
    logic [5:0] op, fn; logic [31:0] a, b;
    logic [2:0] ctrl; int lat; logic [31:0] res; logic z, ill, dz;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive a request, let it be accepted, return at the first negedge after accept
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1; req_opcode = op; req_funct = fn; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 0;
  endtask

  // count EXEC negedges until rsp_valid, noting whether ALU inputs ever moved
  task automatic wait_rsp(input vec_t v, output int n, output logic held);
    n = 0; held = 1;
    while (!rsp_valid && n < 40) begin
      if (alu_ctrl !== v.ctrl || alu_a !== v.a || alu_b !== v.b || req_ready !== 1'b0) held = 0;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, seen;
    logic held;
    vec_t v;
    //          op     fn     a             b             ctrl   lat res           z ill dz
    vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        3'b000, 1, 32'd12,        0, 0, 0};
    vecs[1]  = '{6'h04, 6'h00, 32'h1234,     32'h1234,     3'b001, 1, 32'd0,         1, 0, 0};
    vecs[2]  = '{6'h00, 6'h18, 32'd6,        32'd7,        3'b010, 4, 32'd42,        0, 0, 0};
    vecs[3]  = '{6'h00, 6'h1A, 32'd9,        32'd0,        3'b011, 8, 32'hFFFF_FFFF, 0, 0, 1};
    vecs[4]  = '{6'h00, 6'h1A, 32'd100,      32'd7,        3'b011, 8, 32'd14,        0, 0, 0};
    vecs[5]  = '{6'h0C, 6'h00, 32'hF0F0,     32'h0FF0,     3'b100, 1, 32'h00F0,      0, 0, 0};
    vecs[6]  = '{6'h0D, 6'h00, 32'hF000,     32'h000F,     3'b101, 1, 32'hF00F,      0, 0, 0};
    vecs[7]  = '{6'h0E, 6'h00, 32'hFF,       32'hFF,       3'b110, 1, 32'd0,         1, 0, 0};
    vecs[8]  = '{6'h3F, 6'h00, 32'hDEADBEEF, 32'd1,        3'b111, 1, 32'hDEADBEEF,  0, 1, 0};
    vecs[9]  = '{6'h00, 6'h00, 32'd0,        32'd5,        3'b111, 1, 32'd0,         1, 1, 0};
    vecs[10] = '{6'h23, 6'h00, 32'd100,      32'd4,        3'b000, 1, 32'd104,       0, 0, 0};
    vecs[11] = '{6'h00, 6'h23, 32'd3,        32'd5,        3'b001, 1, 32'hFFFF_FFFE, 0, 0, 0};
    vecs[12] = '{6'h00, 6'h18, 32'd0,        32'd123,      3'b010, 4, 32'd0,         1, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd7);
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_inp_a", alu_a, 0);
    chk("rst_flags", {29'd0, rsp_zero, rsp_illegal, rsp_div_zero}, 0);

    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      issue(v.op, v.fn, v.a, v.b);
      chk($sformatf("v%0d_ctrl", i), {29'd0, alu_ctrl}, {29'd0, v.ctrl});
      chk($sformatf("v%0d_req_ready_busy", i), {31'd0, req_ready}, 0);
      wait_rsp(v, n, held);
      chk($sformatf("v%0d_held", i), {31'd0, held}, 1);
      chk($sformatf("v%0d_latency", i), n, v.lat);
      chk($sformatf("v%0d_result", i), rsp_result, v.res);
      chk($sformatf("v%0d_flags", i), {29'd0, rsp_zero, rsp_illegal, rsp_div_zero}, {29'd0, v.z, v.ill, v.dz});
      @(negedge clk);
      chk($sformatf("v%0d_valid_after_hs", i), {31'd0, rsp_valid}, 0);
      chk($sformatf("v%0d_ready_after_hs", i), {31'd0, req_ready}, 1);
    end

    // backpressure: response must stay put and no new request may slip in
    rsp_ready = 0;
    v = vecs[0];
    issue(v.op, v.fn, v.a, v.b);
    wait_rsp(v, n, held);
    chk("bp_latency", n, 1);
    req_valid = 1; req_opcode = 6'h00; req_funct = 6'h22; req_a = 32'd50; req_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, rsp_valid}, 1);
      chk($sformatf("bp_result_%0d", k), rsp_result, 32'd12);
      chk($sformatf("bp_req_ready_%0d", k), {31'd0, req_ready}, 0);
      @(negedge clk);
    end
    chk("bp_ctrl_unchanged", {29'd0, alu_ctrl}, 32'd0);
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 0);
    chk("bp_release_ready", {31'd0, req_ready}, 1);
    chk("bp_result_holds_idle", rsp_result, 32'd12);

    // reset in EXEC cycle 3 of a divide discards the operation
    issue(6'h00, 6'h1A, 32'd9, 32'd3);
    repeat (2) @(negedge clk);
    chk("mid_busy", {31'd0, req_ready}, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_ctrl", {29'd0, alu_ctrl}, 32'd7);
    chk("mid_rst_inp_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, req_ready}, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("mid_rst_no_rsp", seen, 0);
    chk("mid_rst_result", rsp_result, 0);

    // machine still works after the reset
    v = vecs[2];
    issue(v.op, v.fn, v.a, v.b);
    wait_rsp(v, n, held);
    chk("post_rst_latency", n, 4);
    chk("post_rst_result", rsp_result, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
